// File: rtl/line_memory_adapter_pkg.sv
// Shared definitions for the line memory adapter.
//   - Message codes used on both the cache side and the word-wide memory side.
//   - log2 helper used to size the word-offset field of a line address.
//   - FSM state encoding for the adapter.
package line_memory_adapter_pkg;

    localparam int MSG_BITS = 4;

    localparam logic [MSG_BITS-1:0] NO_REQ   = 4'd0;
    localparam logic [MSG_BITS-1:0] R_REQ    = 4'd1;
    localparam logic [MSG_BITS-1:0] WB_REQ   = 4'd2;
    localparam logic [MSG_BITS-1:0] MEM_RESP = 4'd3;

    // Ceiling log2; exact for the power-of-two line sizes used here.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; (1 << i) < value; i++) begin
            result = i + 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

endpackage

// File: rtl/line_memory_adapter_if.sv
// Bundle of the adapter's cache-side and memory-side message buses.
//   cache_*_in  : line request from the last-level cache
//   cache_*_out : one-cycle line response back to the cache
//   mem_*_out   : single-word requests to the main memory controller
//   mem_*_in    : word responses from the main memory controller
// Modports:
//   slave  - the adapter itself
//   master - the surrounding environment (cache + memory controller)
interface line_memory_adapter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 4,
    parameter int WORDS_PER_LINE = 4
);
    logic [MSG_BITS-1:0]                  cache_msg_in;
    logic [ADDRESS_WIDTH-1:0]             cache_address_in;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] cache_data_in;
    logic [MSG_BITS-1:0]                  cache_msg_out;
    logic [ADDRESS_WIDTH-1:0]             cache_address_out;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] cache_data_out;

    logic [MSG_BITS-1:0]                  mem_msg_out;
    logic [ADDRESS_WIDTH-1:0]             mem_address_out;
    logic [DATA_WIDTH-1:0]                mem_data_out;
    logic [MSG_BITS-1:0]                  mem_msg_in;
    logic [ADDRESS_WIDTH-1:0]             mem_address_in;
    logic [DATA_WIDTH-1:0]                mem_data_in;

    modport slave (
        input  cache_msg_in, cache_address_in, cache_data_in,
        output cache_msg_out, cache_address_out, cache_data_out,
        output mem_msg_out, mem_address_out, mem_data_out,
        input  mem_msg_in, mem_address_in, mem_data_in
    );

    modport master (
        output cache_msg_in, cache_address_in, cache_data_in,
        input  cache_msg_out, cache_address_out, cache_data_out,
        input  mem_msg_out, mem_address_out, mem_data_out,
        output mem_msg_in, mem_address_in, mem_data_in
    );

endinterface

// File: rtl/line_memory_adapter.sv
// Line memory adapter: converts a cache-line read or write-back into
// WORDS_PER_LINE single-word memory transactions, reassembles read words
// into a line, and returns a single-cycle MEM_RESP to the cache.
// Ports:
//   clock - system clock
//   reset - synchronous, active-high; abandons any line in flight
//   bus   - cache-side and memory-side message buses (slave modport)
// All outputs are registered.
module line_memory_adapter
    import line_memory_adapter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input logic                  clock,
    input logic                  reset,
    line_memory_adapter_if.slave bus
);

    localparam int OFFSET_BITS = log2(WORDS_PER_LINE);
    localparam int TAG_BITS    = ADDRESS_WIDTH - OFFSET_BITS;

    localparam logic [MSG_BITS-1:0] M_NO_REQ   = MSG_BITS'(NO_REQ);
    localparam logic [MSG_BITS-1:0] M_R_REQ    = MSG_BITS'(R_REQ);
    localparam logic [MSG_BITS-1:0] M_WB_REQ   = MSG_BITS'(WB_REQ);
    localparam logic [MSG_BITS-1:0] M_MEM_RESP = MSG_BITS'(MEM_RESP);
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS_PER_LINE - 1);

    state_t                                       state;
    logic                                         is_read;
    logic [TAG_BITS-1:0]                          line_tag;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]    line;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]    line_next;
    logic [OFFSET_BITS-1:0]                       cnt;
    logic [OFFSET_BITS-1:0]                       cnt_inc;

    // Response address is never checked and offset bits of the request
    // address are discarded; fold them here so they are visibly unused.
    logic unused_bits;
    assign unused_bits = ^{bus.mem_address_in, bus.cache_address_in[OFFSET_BITS-1:0]};

    assign cnt_inc = cnt + 1'b1;

    // Line contents including the word arriving this cycle, so the final
    // read word reaches cache_data_out on the same edge it is captured.
    always_comb begin
        line_next = line;
        if (is_read) begin
            line_next[cnt] = bus.mem_data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= IDLE;
            is_read               <= 1'b0;
            line_tag              <= '0;
            line                  <= '0;
            cnt                   <= '0;
            bus.cache_msg_out     <= M_NO_REQ;
            bus.cache_address_out <= '0;
            bus.cache_data_out    <= '0;
            bus.mem_msg_out       <= M_NO_REQ;
            bus.mem_address_out   <= '0;
            bus.mem_data_out      <= '0;
        end else begin
            // Cache response is a one-cycle pulse; drop it unless re-armed below.
            bus.cache_msg_out     <= M_NO_REQ;
            bus.cache_address_out <= '0;
            bus.cache_data_out    <= '0;

            case (state)
                IDLE: begin
                    if (bus.cache_msg_in == M_R_REQ || bus.cache_msg_in == M_WB_REQ) begin
                        is_read             <= (bus.cache_msg_in == M_R_REQ);
                        line_tag            <= bus.cache_address_in[ADDRESS_WIDTH-1:OFFSET_BITS];
                        line                <= bus.cache_data_in;
                        cnt                 <= '0;
                        bus.mem_msg_out     <= bus.cache_msg_in;
                        bus.mem_address_out <= {bus.cache_address_in[ADDRESS_WIDTH-1:OFFSET_BITS],
                                                {OFFSET_BITS{1'b0}}};
                        bus.mem_data_out    <= (bus.cache_msg_in == M_WB_REQ) ?
                                               bus.cache_data_in[0 +: DATA_WIDTH] : '0;
                        state               <= ISSUE;
                    end
                end

                ISSUE: begin
                    // mem_* outputs hold until the controller answers.
                    if (bus.mem_msg_in == M_MEM_RESP) begin
                        line <= line_next;
                        if (cnt != LAST_WORD) begin
                            cnt                 <= cnt_inc;
                            bus.mem_address_out <= {line_tag, cnt_inc};
                            bus.mem_data_out    <= is_read ? '0 : line[cnt_inc];
                        end else begin
                            cnt                   <= '0;
                            bus.mem_msg_out       <= M_NO_REQ;
                            bus.mem_address_out   <= '0;
                            bus.mem_data_out      <= '0;
                            bus.cache_msg_out     <= M_MEM_RESP;
                            bus.cache_address_out <= {line_tag, {OFFSET_BITS{1'b0}}};
                            bus.cache_data_out    <= is_read ? line_next : '0;
                            state                 <= RESP;
                        end
                    end
                end

                // MEM_RESP pulse is visible during this state; cache inputs
                // are deliberately not sampled here.
                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_memory_adapter.sv
// Testbench for line_memory_adapter with a behavioural word memory:
// read responses arrive 2 cycles after a request appears, write responses
// 1 cycle after; memory word k is preloaded with 0x1000+k.
module tb_line_memory_adapter;
    import line_memory_adapter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    line_memory_adapter_if bus ();

    line_memory_adapter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  msg;
        logic [31:0] addr;
        logic [31:0] data;
    } log_t;
    log_t txn_log[$];
    bit   spur;

    // Memory controller model, acting on the falling edge.
    initial begin
        logic [31:0] mem [0:255];
        int age;
        int lat;
        log_t e;
        for (int k = 0; k < 256; k++) mem[k] = 32'h1000 + k;
        age = 0;
        bus.mem_msg_in     = NO_REQ;
        bus.mem_address_in = '0;
        bus.mem_data_in    = '0;
        forever begin
            @(negedge clock);
            if (bus.mem_msg_in == MEM_RESP) begin
                bus.mem_msg_in     = NO_REQ;
                bus.mem_address_in = '0;
                bus.mem_data_in    = '0;
                age = 0;
            end
            if (spur) begin
                bus.mem_msg_in  = MEM_RESP;
                bus.mem_data_in = 32'hBAD0BAD0;
            end else if (bus.mem_msg_out == R_REQ || bus.mem_msg_out == WB_REQ) begin
                lat = (bus.mem_msg_out == R_REQ) ? 2 : 1;
                if (age == lat) begin
                    e.msg  = bus.mem_msg_out;
                    e.addr = bus.mem_address_out;
                    e.data = bus.mem_data_out;
                    txn_log.push_back(e);
                    if (bus.mem_msg_out == WB_REQ) begin
                        mem[bus.mem_address_out[7:0]] = bus.mem_data_out;
                        bus.mem_data_in = '0;
                    end else begin
                        bus.mem_data_in = mem[bus.mem_address_out[7:0]];
                    end
                    bus.mem_msg_in     = MEM_RESP;
                    bus.mem_address_in = bus.mem_address_out;
                    age = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request, scramble the cache inputs after acceptance, and
    // wait (bounded) for the MEM_RESP pulse. lat counts edges from acceptance.
    task automatic run_txn(input logic [3:0] msg, input logic [31:0] addr,
                           input logic [127:0] data, output int lat, output bit got,
                           output logic [31:0] raddr, output logic [127:0] rdata);
        @(posedge clock); #1;
        bus.cache_msg_in     = msg;
        bus.cache_address_in = addr;
        bus.cache_data_in    = data;
        lat = 0; got = 0; raddr = '0; rdata = '0;
        while (!got && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) begin
                bus.cache_data_in    = ~data;
                bus.cache_address_in = ~addr;
            end
            if (bus.cache_msg_out == MEM_RESP) begin
                got   = 1;
                raddr = bus.cache_address_out;
                rdata = bus.cache_data_out;
            end
        end
        bus.cache_msg_in = NO_REQ;
    endtask

    task automatic check_log(input string tag, input int start, input logic [3:0] msg,
                             input logic [31:0] base, input logic [127:0] data);
        log_t e;
        check({tag, " word count"}, txn_log.size() - start, 4);
        for (int i = 0; i < 4; i++) begin
            if (start + i < txn_log.size()) begin
                e = txn_log[start + i];
                check($sformatf("%s w%0d msg", tag, i), e.msg, msg);
                check($sformatf("%s w%0d addr", tag, i), e.addr, base + i);
                check($sformatf("%s w%0d data", tag, i), e.data,
                      (msg == WB_REQ) ? data[i*32 +: 32] : 32'h0);
            end
        end
    endtask

    typedef struct {
        logic [3:0]   msg;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [31:0]  exp_base;
        logic [127:0] exp_line;
        int           exp_lat;
    } vec_t;

    initial begin
        vec_t         vecs [6];
        int           lat;
        bit           got;
        logic [31:0]  raddr;
        logic [127:0] rdata;
        int           start;
        int           cnt;
        string        tag;

        vecs[0] = '{R_REQ,  32'h20, {4{32'hFFFF_FFFF}}, 32'h20,
                    {32'h1023, 32'h1022, 32'h1021, 32'h1020}, 13};
        vecs[1] = '{WB_REQ, 32'h40, {32'hD, 32'hC, 32'hB, 32'hA}, 32'h40, 128'h0, 9};
        vecs[2] = '{R_REQ,  32'h40, 128'h0, 32'h40, {32'hD, 32'hC, 32'hB, 32'hA}, 13};
        vecs[3] = '{R_REQ,  32'h23, 128'h0, 32'h20,
                    {32'h1023, 32'h1022, 32'h1021, 32'h1020}, 13};
        vecs[4] = '{WB_REQ, 32'h81, {32'h44, 32'h33, 32'h22, 32'h11}, 32'h80, 128'h0, 9};
        vecs[5] = '{R_REQ,  32'h82, 128'h0, 32'h80, {32'h44, 32'h33, 32'h22, 32'h11}, 13};

        reset = 1'b1;
        spur  = 1'b0;
        bus.cache_msg_in     = NO_REQ;
        bus.cache_address_in = '0;
        bus.cache_data_in    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset cache_msg_out", bus.cache_msg_out, NO_REQ);
        check("reset cache_address_out", bus.cache_address_out, 0);
        check("reset cache_data_out", bus.cache_data_out, 0);
        check("reset mem_msg_out", bus.mem_msg_out, NO_REQ);
        check("reset mem_address_out", bus.mem_address_out, 0);
        check("reset mem_data_out", bus.mem_data_out, 0);
        reset = 1'b0;

        // Table of line transactions; each one starts the cycle after the
        // previous MEM_RESP, so these also run back to back.
        for (int k = 0; k < 6; k++) begin
            tag   = $sformatf("v%0d", k);
            start = txn_log.size();
            run_txn(vecs[k].msg, vecs[k].addr, vecs[k].data, lat, got, raddr, rdata);
            check({tag, " got resp"}, got, 1);
            check({tag, " latency"}, lat, vecs[k].exp_lat);
            check({tag, " resp addr"}, raddr, vecs[k].exp_base);
            check({tag, " resp data"}, rdata, vecs[k].exp_line);
            check_log(tag, start, vecs[k].msg, vecs[k].exp_base, vecs[k].data);
        end

        // Back-to-back read right after a read; no repeat of the first response.
        run_txn(R_REQ, 32'h20, 128'h0, lat, got, raddr, rdata);
        check("b2b first addr", raddr, 32'h20);
        run_txn(R_REQ, 32'h60, 128'h0, lat, got, raddr, rdata);
        check("b2b second got", got, 1);
        check("b2b second latency", lat, 13);
        check("b2b second addr", raddr, 32'h60);
        check("b2b second data", rdata, {32'h1063, 32'h1062, 32'h1061, 32'h1060});
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (bus.cache_msg_out == MEM_RESP) cnt++;
        end
        check("b2b extra responses", cnt, 0);

        // Reset during the second word of a read.
        @(posedge clock); #1;
        bus.cache_msg_in     = R_REQ;
        bus.cache_address_in = 32'h20;
        cnt = 0;
        while (bus.mem_address_out != 32'h21 && cnt < 30) begin
            @(posedge clock); #1;
            cnt++;
        end
        check("midreset reached word1", bus.mem_address_out, 32'h21);
        reset = 1'b1;
        bus.cache_msg_in = NO_REQ;
        @(posedge clock); #1;
        check("midreset mem_msg_out", bus.mem_msg_out, NO_REQ);
        check("midreset mem_address_out", bus.mem_address_out, 0);
        check("midreset mem_data_out", bus.mem_data_out, 0);
        check("midreset cache_msg_out", bus.cache_msg_out, NO_REQ);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (bus.cache_msg_out == MEM_RESP || bus.mem_msg_out != NO_REQ) cnt++;
        end
        check("midreset activity after", cnt, 0);
        start = txn_log.size();
        run_txn(R_REQ, 32'h40, 128'h0, lat, got, raddr, rdata);
        check("postreset latency", lat, 13);
        check("postreset data", rdata, {32'hD, 32'hC, 32'hB, 32'hA});
        check_log("postreset", start, R_REQ, 32'h40, 128'h0);

        // Spurious memory responses while idle must not move the adapter.
        @(posedge clock); #1;
        spur = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (bus.cache_msg_out != NO_REQ || bus.mem_msg_out != NO_REQ) cnt++;
        end
        spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (bus.cache_msg_out != NO_REQ || bus.mem_msg_out != NO_REQ) cnt++;
        end
        check("spurious idle activity", cnt, 0);
        run_txn(WB_REQ, 32'h5E, {32'h4, 32'h3, 32'h2, 32'h1}, lat, got, raddr, rdata);
        check("after spurious wb latency", lat, 9);
        check("after spurious wb addr", raddr, 32'h5C);
        run_txn(R_REQ, 32'h5C, 128'h0, lat, got, raddr, rdata);
        check("after spurious rd data", rdata, {32'h4, 32'h3, 32'h2, 32'h1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
